// File: rtl/ex_mem_pkg.sv
// Shared pipeline defines for the EX/MEM register stage: bus widths, NOP/zero
// constants, the stage action decode and the packet carried to MEM.
package ex_mem_pkg;

  localparam int RegBus       = 32;
  localparam int RegAddrBus   = 5;
  localparam int DoubleRegBus = 64;
  localparam int StallBus     = 6;
  localparam int CntBus       = 2;

  localparam logic [RegAddrBus-1:0] NOPRegAddr   = '0;
  localparam logic [RegBus-1:0]     ZeroWord     = '0;
  localparam logic                  WriteEnable  = 1'b1;
  localparam logic                  WriteDisable = 1'b0;
  localparam logic                  Stop         = 1'b1;
  localparam logic                  NoStop       = 1'b0;

  // Stall vector bit positions that this stage cares about.
  localparam int StallBitEx  = 3;
  localparam int StallBitMem = 4;

  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_HOLD    = 2'd2
  } stage_act_e;

  typedef struct packed {
    logic [RegAddrBus-1:0] waddr;
    logic                  reg_we;
    logic [RegBus-1:0]     alu_res;
    logic                  hi_we;
    logic                  lo_we;
    logic [RegBus-1:0]     hi;
    logic [RegBus-1:0]     lo;
  } mem_pkt_t;

  localparam mem_pkt_t MEM_PKT_NOP = '{
    waddr:   NOPRegAddr,
    reg_we:  WriteDisable,
    alu_res: ZeroWord,
    hi_we:   WriteDisable,
    lo_we:   WriteDisable,
    hi:      ZeroWord,
    lo:      ZeroWord
  };

  // EX stalled with MEM free inserts a bubble; EX running always advances,
  // even if MEM reports a stall, so only both stalled means hold.
  function automatic stage_act_e stage_act(input logic stall_ex, input logic stall_mem);
    stage_act_e act;
    if (stall_ex == NoStop) begin
      act = ACT_ADVANCE;
    end else if (stall_mem == NoStop) begin
      act = ACT_BUBBLE;
    end else begin
      act = ACT_HOLD;
    end
    return act;
  endfunction

endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: one-cycle, flop-only stage between execute and memory.
// Define EX_MEM_MADD_EN to keep the madd/msub partial product and step counter flops.
module ex_mem
  import ex_mem_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  input  logic [RegAddrBus-1:0]   ex_waddr,
  input  logic                    ex_reg_we,
  input  logic [RegBus-1:0]       ex_alu_res,
  input  logic                    ex_hi_we,
  input  logic                    ex_lo_we,
  input  logic [RegBus-1:0]       ex_hi,
  input  logic [RegBus-1:0]       ex_lo,
  input  logic [DoubleRegBus-1:0] hilo_temp_i,
  input  logic [CntBus-1:0]       cnt_i,
  output logic [RegAddrBus-1:0]   mem_waddr,
  output logic                    mem_reg_we,
  output logic [RegBus-1:0]       mem_alu_res,
  output logic                    mem_hi_we,
  output logic                    mem_lo_we,
  output logic [RegBus-1:0]       mem_hi,
  output logic [RegBus-1:0]       mem_lo,
  output logic [DoubleRegBus-1:0] hilo_temp_o,
  output logic [CntBus-1:0]       cnt_o
);

  stage_act_e act;
  mem_pkt_t   ex_pkt;
  mem_pkt_t   mem_reg;
  mem_pkt_t   mem_next;

  assign act = stage_act(stall[StallBitEx], stall[StallBitMem]);

  // Remaining stall bits belong to other stages.
  logic unused_stall;
  assign unused_stall = ^{stall[StallBus-1:StallBitMem+1], stall[StallBitEx-1:0]};

  assign ex_pkt = '{
    waddr:   ex_waddr,
    reg_we:  ex_reg_we,
    alu_res: ex_alu_res,
    hi_we:   ex_hi_we,
    lo_we:   ex_lo_we,
    hi:      ex_hi,
    lo:      ex_lo
  };

  always_comb begin
    mem_next = mem_reg;
    unique case (act)
      ACT_ADVANCE: mem_next = ex_pkt;
      ACT_BUBBLE:  mem_next = MEM_PKT_NOP;
      default:     mem_next = mem_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_reg <= MEM_PKT_NOP;
    end else begin
      mem_reg <= mem_next;
    end
  end

  assign mem_waddr   = mem_reg.waddr;
  assign mem_reg_we  = mem_reg.reg_we;
  assign mem_alu_res = mem_reg.alu_res;
  assign mem_hi_we   = mem_reg.hi_we;
  assign mem_lo_we   = mem_reg.lo_we;
  assign mem_hi      = mem_reg.hi;
  assign mem_lo      = mem_reg.lo;

`ifdef EX_MEM_MADD_EN
  logic [DoubleRegBus-1:0] hilo_temp_reg;
  logic [DoubleRegBus-1:0] hilo_temp_next;
  logic [CntBus-1:0]       cnt_reg;
  logic [CntBus-1:0]       cnt_next;

  // While EX is stalled mid madd/msub its partial state loops back through
  // here; any advance means the operation finished, so the state is cleared.
  always_comb begin
    hilo_temp_next = hilo_temp_reg;
    cnt_next       = cnt_reg;
    unique case (act)
      ACT_ADVANCE: begin
        hilo_temp_next = '0;
        cnt_next       = '0;
      end
      ACT_BUBBLE: begin
        hilo_temp_next = hilo_temp_i;
        cnt_next       = cnt_i;
      end
      default: begin
        hilo_temp_next = hilo_temp_reg;
        cnt_next       = cnt_reg;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hilo_temp_reg <= '0;
      cnt_reg       <= '0;
    end else begin
      hilo_temp_reg <= hilo_temp_next;
      cnt_reg       <= cnt_next;
    end
  end

  assign hilo_temp_o = hilo_temp_reg;
  assign cnt_o       = cnt_reg;
`else
  logic unused_madd;
  assign unused_madd = ^{hilo_temp_i, cnt_i};

  assign hilo_temp_o = '0;
  assign cnt_o       = '0;
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem: vector table, async reset sequences, and
// randomized stimulus against a rule-level model of the stage.
module tb_ex_mem;
  import ex_mem_pkg::*;

`ifdef EX_MEM_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  waddr;
    logic        reg_we;
    logic [31:0] alu;
    logic        hi_we;
    logic [31:0] hi;
    logic        lo_we;
    logic [31:0] lo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } stage_t;

  typedef struct {
    logic [5:0] stall;
    stage_t     in_v;
    stage_t     exp_v;
  } vec_t;

  localparam stage_t ZERO = '0;
  localparam int NVEC = 13;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic [4:0]  ex_waddr = '0;
  logic        ex_reg_we = 1'b0;
  logic [31:0] ex_alu_res = '0;
  logic        ex_hi_we = 1'b0;
  logic        ex_lo_we = 1'b0;
  logic [31:0] ex_hi = '0;
  logic [31:0] ex_lo = '0;
  logic [63:0] hilo_temp_i = '0;
  logic [1:0]  cnt_i = '0;
  logic [4:0]  mem_waddr;
  logic        mem_reg_we;
  logic [31:0] mem_alu_res;
  logic        mem_hi_we;
  logic        mem_lo_we;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;

  int checks = 0;
  int errors = 0;
  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  ex_mem dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ex_waddr(ex_waddr), .ex_reg_we(ex_reg_we), .ex_alu_res(ex_alu_res),
    .ex_hi_we(ex_hi_we), .ex_lo_we(ex_lo_we), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
    .mem_waddr(mem_waddr), .mem_reg_we(mem_reg_we), .mem_alu_res(mem_alu_res),
    .mem_hi_we(mem_hi_we), .mem_lo_we(mem_lo_we), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
  );

  function automatic stage_t mk(input logic [4:0] waddr, input logic reg_we,
                                input logic [31:0] alu, input logic hi_we,
                                input logic [31:0] hi, input logic lo_we,
                                input logic [31:0] lo, input logic [63:0] hilo,
                                input logic [1:0] cnt);
    stage_t s;
    s.waddr = waddr; s.reg_we = reg_we; s.alu = alu;
    s.hi_we = hi_we; s.hi = hi; s.lo_we = lo_we; s.lo = lo;
    s.hilo = hilo; s.cnt = cnt;
    return s;
  endfunction

  // Behavioural rule for one clock of the stage, straight from the stall rules.
  function automatic stage_t model_next(input stage_t cur, input logic [5:0] s, input stage_t in_v);
    stage_t n;
    if (s[3] == 1'b0) begin
      n = in_v;
      n.hilo = 64'd0;
      n.cnt = 2'd0;
    end else if (s[4] == 1'b0) begin
      n = ZERO;
      n.hilo = in_v.hilo;
      n.cnt = in_v.cnt;
    end else begin
      n = cur;
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_all(input string tag, input stage_t e);
    stage_t ee;
    ee = e;
    if (!MADD) begin
      ee.hilo = 64'd0;
      ee.cnt = 2'd0;
    end
    check({tag, ".mem_waddr"},   {59'd0, mem_waddr},   {59'd0, ee.waddr});
    check({tag, ".mem_reg_we"},  {63'd0, mem_reg_we},  {63'd0, ee.reg_we});
    check({tag, ".mem_alu_res"}, {32'd0, mem_alu_res}, {32'd0, ee.alu});
    check({tag, ".mem_hi_we"},   {63'd0, mem_hi_we},   {63'd0, ee.hi_we});
    check({tag, ".mem_hi"},      {32'd0, mem_hi},      {32'd0, ee.hi});
    check({tag, ".mem_lo_we"},   {63'd0, mem_lo_we},   {63'd0, ee.lo_we});
    check({tag, ".mem_lo"},      {32'd0, mem_lo},      {32'd0, ee.lo});
    check({tag, ".hilo_temp_o"}, hilo_temp_o,          ee.hilo);
    check({tag, ".cnt_o"},       {62'd0, cnt_o},       {62'd0, ee.cnt});
  endtask

  task automatic drive(input logic [5:0] s, input stage_t v);
    stall = s;
    ex_waddr = v.waddr; ex_reg_we = v.reg_we; ex_alu_res = v.alu;
    ex_hi_we = v.hi_we; ex_hi = v.hi; ex_lo_we = v.lo_we; ex_lo = v.lo;
    hilo_temp_i = v.hilo; cnt_i = v.cnt;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge: drops reset mid-cycle, expects
  // outputs cleared before the next edge, then holds reset across an edge.
  task automatic reset_midcycle(input string tag);
    #2 rst = 1'b0;
    #1;
    check_all({tag, ".async"}, ZERO);
    drive(6'b000000, mk(5'd17, 1'b1, 32'hFFFF0000, 1'b1, 32'h1, 1'b1, 32'h2, 64'h3, 2'd3));
    step;
    check_all({tag, ".held"}, ZERO);
    $display("%s: reset mid-cycle cleared outputs", tag);
    rst = 1'b1;
  endtask

  initial begin
    stage_t model;
    stage_t in_v;
    logic [5:0] s;

    vecs[0]  = '{6'b000000, mk(5'd5, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 32'h0, 64'h123, 2'd2),
                            mk(5'd5, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 32'h0, 64'h0, 2'd0)};
    vecs[1]  = '{6'b001111, mk(5'd7, 1'b1, 32'h1111, 1'b1, 32'h22, 1'b1, 32'h33, 64'h0000_0001_FFFF_FFFE, 2'd1),
                            mk(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 64'h0000_0001_FFFF_FFFE, 2'd1)};
    vecs[2]  = '{6'b000000, mk(5'd3, 1'b0, 32'hCAFE, 1'b0, 32'h0, 1'b0, 32'h0, 64'hFFFF, 2'd3),
                            mk(5'd3, 1'b0, 32'hCAFE, 1'b0, 32'h0, 1'b0, 32'h0, 64'h0, 2'd0)};
    vecs[3]  = '{6'b000000, mk(5'd9, 1'b1, 32'h42, 1'b1, 32'hAAAA0000, 1'b0, 32'h0, 64'h0, 2'd0),
                            mk(5'd9, 1'b1, 32'h42, 1'b1, 32'hAAAA0000, 1'b0, 32'h0, 64'h0, 2'd0)};
    for (int i = 4; i < 7; i++) begin
      vecs[i] = '{6'b011111, mk(5'd1, 1'b0, 32'h7, 1'b1, 32'h55555555, 1'b1, 32'h99, 64'hABC, 2'd2),
                             mk(5'd9, 1'b1, 32'h42, 1'b1, 32'hAAAA0000, 1'b0, 32'h0, 64'h0, 2'd0)};
    end
    vecs[7]  = '{6'b010000, mk(5'd2, 1'b1, 32'h8, 1'b0, 32'h0, 1'b1, 32'h1, 64'h77, 2'd1),
                            mk(5'd2, 1'b1, 32'h8, 1'b0, 32'h0, 1'b1, 32'h1, 64'h0, 2'd0)};
    vecs[8]  = '{6'b101000, mk(5'd4, 1'b1, 32'h5, 1'b1, 32'h6, 1'b1, 32'h7, 64'h8000_0000_0000_0001, 2'd3),
                            mk(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 64'h8000_0000_0000_0001, 2'd3)};
    vecs[9]  = '{6'b111000, mk(5'd6, 1'b1, 32'h9, 1'b1, 32'h1, 1'b1, 32'h1, 64'h5, 2'd1),
                            mk(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 64'h8000_0000_0000_0001, 2'd3)};
    vecs[10] = '{6'b000111, mk(5'd31, 1'b1, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 64'h1, 2'd1),
                            mk(5'd31, 1'b1, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 64'h0, 2'd0)};
    vecs[11] = '{6'b001000, mk(5'd8, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 64'hDEAD_0000_BEEF_0000, 2'd2),
                            mk(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 64'hDEAD_0000_BEEF_0000, 2'd2)};
    vecs[12] = '{6'b011000, mk(5'd8, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 64'h1234, 2'd1),
                            mk(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 64'hDEAD_0000_BEEF_0000, 2'd2)};

    // Power-on reset, asserted asynchronously.
    #2 rst = 1'b0;
    #1;
    check_all("por", ZERO);
    drive(6'b000000, mk(5'd1, 1'b1, 32'h1, 1'b1, 32'h1, 1'b1, 32'h1, 64'h1, 2'd1));
    step;
    step;
    check_all("por_held", ZERO);
    $display("por: outputs zero under reset");
    rst = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].stall, vecs[i].in_v);
      step;
      check_all($sformatf("vec%0d", i), vecs[i].exp_v);
      $display("vec%0d stall=%b waddr=%0d alu=%h hilo=%h cnt=%0d", i, vecs[i].stall,
               mem_waddr, mem_alu_res, hilo_temp_o, cnt_o);
    end

    // Reset while a result is in flight.
    drive(6'b000000, mk(5'd12, 1'b1, 32'h12345678, 1'b0, 32'h0, 1'b0, 32'h0, 64'h0, 2'd0));
    step;
    check_all("load_12345678", mk(5'd12, 1'b1, 32'h12345678, 1'b0, 32'h0, 1'b0, 32'h0, 64'h0, 2'd0));
    reset_midcycle("rst_alu");

    // Reset in the middle of a stalled madd/msub.
    drive(6'b001111, mk(5'd3, 1'b1, 32'h3, 1'b0, 32'h0, 1'b0, 32'h0, 64'hFEDC_BA98_7654_3210, 2'd1));
    step;
    check_all("madd_partial", mk(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 64'hFEDC_BA98_7654_3210, 2'd1));
    reset_midcycle("rst_madd");

    // First edge after reset release behaves normally.
    model = mk(5'd21, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b1, 32'h5A5A5A5A, 64'h0, 2'd0);
    drive(6'b000000, mk(5'd21, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b1, 32'h5A5A5A5A, 64'h99, 2'd3));
    step;
    check_all("post_reset", model);
    $display("post_reset: first edge advanced waddr=%0d", mem_waddr);

    for (int i = 0; i < 200; i++) begin
      s = 6'($urandom);
      in_v = mk(5'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom,
                1'($urandom), $urandom, {$urandom, $urandom}, 2'($urandom));
      drive(s, in_v);
      model = model_next(model, s, in_v);
      step;
      check_all($sformatf("rand%0d", i), model);
      $display("rand%0d stall=%b waddr=%0d alu=%h cnt=%0d", i, s, mem_waddr, mem_alu_res, cnt_o);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 Parameters (widths from shared defines): RegBus, 32, data word width; RegAddrBus, 5, register address width; DoubleRegBus, 64, HI/LO accumulator width; StallBus, 6, stall vector width (bit 0 = PC ... bit 5 = WB).
REQ-002 clk  in  1  pipeline clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-low.
REQ-004 stall  in  StallBus  global stall vector; bit 3 = EX held, bit 4 = MEM held.
REQ-005 ex_waddr  in  RegAddrBus  destination register address from EX.
REQ-006 ex_reg_we  in  1  destination register write enable from EX.
REQ-007 ex_alu_res  in  RegBus  ALU result from EX.
REQ-008 ex_hi_we / ex_lo_we  in  1 each  HI / LO write enables from EX.
REQ-009 ex_hi / ex_lo  in  RegBus each  HI / LO write data from EX.
REQ-010 hilo_temp_i  in  DoubleRegBus  partial product from EX for two-cycle madd/msub.
REQ-011 cnt_i  in  2  EX multi-cycle step counter.
REQ-012 mem_waddr, mem_reg_we, mem_alu_res, mem_hi_we, mem_lo_we, mem_hi, mem_lo  out  matching widths  registered copies presented to the MEM stage.
REQ-013 hilo_temp_o  out  DoubleRegBus; cnt_o  out  2  registered multi-cycle state returned to EX.

Function
REQ-014 Latency SHALL be exactly one clock: inputs sampled at edge N appear on outputs after edge N.
REQ-015 Advance (stall[3]=0): all mem_* outputs SHALL load their ex_* inputs; hilo_temp_o SHALL load 0; cnt_o SHALL load 0.
REQ-016 Bubble (stall[3]=1, stall[4]=0): mem_waddr SHALL load NOPRegAddr (0), all enables 0, all data 0; hilo_temp_o SHALL load hilo_temp_i; cnt_o SHALL load cnt_i.
REQ-017 Hold (stall[3]=1, stall[4]=1): every output SHALL keep its current value.
REQ-018 Bubble/hold decision SHALL use only stall[3] and stall[4]; other stall bits SHALL be ignored.
REQ-019 The three cases SHALL be mutually exclusive and exhaustive; stall[3]=0 with stall[4]=1 SHALL be treated as advance.
REQ-020 Outputs SHALL be driven only from flops; no combinational input-to-output path.
REQ-021 No arithmetic performed; data SHALL pass bit-exact, no width change.

Reset
REQ-022 While rst=0 all outputs SHALL be 0 (mem_waddr = NOPRegAddr), asserted asynchronously without waiting for clk.
REQ-023 Reset asserted mid madd/msub SHALL discard hilo_temp_o and cnt_o; no partial state survives.
REQ-024 First edge after rst deasserts SHALL follow REQ-015..017 normally.

Configuration
REQ-025 Macro EX_MEM_MADD_EN: defined -> hilo_temp/cnt flops present and behave per REQ-015..017.
REQ-026 Not defined -> hilo_temp_o and cnt_o SHALL be constant 0, no flops inferred, hilo_temp_i/cnt_i ignored; all other behaviour unchanged.

Structure
REQ-027 RegBus, RegAddrBus, DoubleRegBus, StallBus, NOPRegAddr, ZeroWord, WriteEnable/WriteDisable, Stop/NoStop SHALL live in the shared defines package; no local redefinition.
REQ-028 No sub-module; single flat register stage.

Verification
REQ-029 Reset: rst=0 mid-cycle with mem_alu_res=0x12345678 -> all outputs 0 immediately, before next clk edge.
REQ-030 Advance: stall=0, ex_waddr=5, ex_reg_we=1, ex_alu_res=0xDEADBEEF -> next edge mem_waddr=5, mem_reg_we=1, mem_alu_res=0xDEADBEEF, cnt_o=0.
REQ-031 Bubble: stall=6'b001111, hilo_temp_i=0x0000_0001_FFFF_FFFE, cnt_i=1 -> mem_reg_we=0, mem_waddr=0, hilo_temp_o=0x0000_0001_FFFF_FFFE, cnt_o=1; next edge with stall=0 -> cnt_o=0, hilo_temp_o=0.
REQ-032 Hold: load ex_hi=0xAAAA0000 with ex_hi_we=1, then stall=6'b011111 for 3 cycles while ex_hi=0x55555555 -> mem_hi stays 0xAAAA0000, mem_hi_we stays 1.
REQ-033 stall=6'b010000 with ex_lo=0x1 and ex_lo_we=1 -> treated as advance: mem_lo=0x1, mem_lo_we=1.
REQ-034 EX_MEM_MADD_EN undefined: repeat REQ-031 -> hilo_temp_o=0 and cnt_o=0 throughout; other outputs per REQ-031.
